// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: scans a 16-bit hex value across a 4-digit common-anode
// seven-segment display, one nibble at a time.
// Each digit is driven for DIV cycles, then all anodes stay off for GAP
// cycles. A pending register holds loaded values until the next frame
// boundary, so a frame never mixes old and new digits.
// Optional build macro: SSD_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module ssd_scan_driver #(
    parameter int DIV   = 100000,
    parameter int GAP   = 2,
    parameter int CNT_W = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  nibble,
    output logic [3:0]  anode,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    typedef enum logic {
        S_DRIVE = 1'b0,
        S_GAP   = 1'b1
    } state_t;

    // Terminal counts. GAP = 0 removes the blanking slot entirely; the
    // GAP state is then only reached out of reset and left on the next edge.
    localparam bit              HAS_GAP    = (GAP > 0);
    localparam int              GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LAST_I);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [1:0]         idx_nxt;
    logic               advance;
    logic               boundary;

    logic [15:0]        display;
    logic [15:0]        display_nxt;
    logic [3:0]         display_dp;
    logic [3:0]         display_dp_nxt;
    logic [15:0]        pending;
    logic [3:0]         pending_dp;
    logic               pending_valid;
    logic               pending_valid_nxt;

    logic [3:0]         anode_nxt;
    logic [3:0]         nibble_nxt;
    logic               dp_nxt;
    logic               blank;

    // Next-state logic: slot counter, DRIVE/GAP sequencing and digit advance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        advance   = 1'b0;
        case (state)
            S_DRIVE: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt = '0;
                    if (HAS_GAP) begin
                        state_nxt = S_GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!HAS_GAP || (cnt == GAP_LAST)) begin
                    cnt_nxt = '0;
                    advance = 1'b1;
                end
            end
            default: begin
                state_nxt = S_GAP;
                cnt_nxt   = '0;
            end
        endcase
        if (advance) begin
            state_nxt = S_DRIVE;
        end
        idx_nxt  = advance ? (digit_idx + 2'd1) : digit_idx;
        boundary = advance && (digit_idx == 2'd3);
    end

    // Shadow update: display only changes on the edge that starts digit 0.
    // A load on that very edge bypasses pending and is shown immediately.
    always_comb begin
        display_nxt       = display;
        display_dp_nxt    = display_dp;
        pending_valid_nxt = pending_valid;
        if (boundary) begin
            if (load) begin
                display_nxt    = value;
                display_dp_nxt = dp_in;
            end else if (pending_valid) begin
                display_nxt    = pending;
                display_dp_nxt = pending_dp;
            end
            pending_valid_nxt = 1'b0;
        end else if (load) begin
            pending_valid_nxt = 1'b1;
        end
    end

`ifdef SSD_SCAN_LZ_BLANK_EN
    logic lz_zero;

    // Leading-zero detect on the digit about to be driven; digit 0 never
    // blanks and a digit carrying a decimal point is always shown.
    always_comb begin
        lz_zero = 1'b0;
        case (idx_nxt)
            2'd1:    lz_zero = (display_nxt[15:4]  == 12'h000);
            2'd2:    lz_zero = (display_nxt[15:8]  == 8'h00);
            2'd3:    lz_zero = (display_nxt[15:12] == 4'h0);
            default: lz_zero = 1'b0;
        endcase
        blank = lz_zero && !display_dp_nxt[idx_nxt];
    end
`else
    assign blank = 1'b0;
`endif

    // Output look-ahead: outputs are computed from next-cycle state so the
    // registered anode/nibble/dp switch on the same edge as the state.
    always_comb begin
        anode_nxt  = 4'b1111;
        nibble_nxt = nibble;
        dp_nxt     = dp;
        if (state_nxt == S_DRIVE) begin
            nibble_nxt = display_nxt[4*idx_nxt +: 4];
            dp_nxt     = ~display_dp_nxt[idx_nxt];
            if (!blank) begin
                anode_nxt = ~(4'b0001 << idx_nxt);
            end
        end
    end

    // Sequencer registers; digit_idx resets to 3 so the first DRIVE is digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_GAP;
            cnt       <= '0;
            digit_idx <= 2'd3;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            digit_idx <= idx_nxt;
        end
    end

    // Registered display drive; reset blanks the display at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode       <= 4'b1111;
            nibble      <= 4'h0;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            anode       <= anode_nxt;
            nibble      <= nibble_nxt;
            dp          <= dp_nxt;
            frame_start <= boundary;
        end
    end

    // Shown value and pending flag; reset discards any pending load.
    always_ff @(posedge clk) begin
        if (reset) begin
            display       <= 16'h0000;
            display_dp    <= 4'b0000;
            pending_valid <= 1'b0;
        end else begin
            display       <= display_nxt;
            display_dp    <= display_dp_nxt;
            pending_valid <= pending_valid_nxt;
        end
    end

    // Pending data capture; qualified by pending_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            pending    <= value;
            pending_dp <= dp_in;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: two instances (GAP=1 and GAP=0, DIV=4) share
// stimulus and are compared every cycle against a time-based display model.
// Honours SSD_SCAN_LZ_BLANK_EN when the bundle is built with it.
module tb_ssd_scan_driver;

    localparam int DIV = 4;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;

    logic [3:0]  nib0, an0, nib1, an1;
    logic        dp0, fs0, dp1, fs1;
    logic [1:0]  idx0, idx1;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state per instance (0: GAP=1, 1: GAP=0)
    int          gapv [2] = '{1, 0};
    int          ncyc;
    int          ph    [2];
    logic [15:0] m_disp[2], m_pend[2];
    logic [3:0]  m_ddp [2], m_pdp [2];
    logic        m_pv  [2];
    logic [3:0]  m_nib [2], e_an[2];
    logic        m_dp  [2], e_fs[2];
    logic [1:0]  e_idx [2];

    ssd_scan_driver #(.DIV(DIV), .GAP(1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .nibble(nib0), .anode(an0), .dp(dp0), .digit_idx(idx0), .frame_start(fs0)
    );

    ssd_scan_driver #(.DIV(DIV), .GAP(0), .CNT_W(4)) dut_g0 (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .nibble(nib1), .anode(an1), .dp(dp1), .digit_idx(idx1), .frame_start(fs1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, ncyc);
        end
    endtask

    // Display model: position in the frame follows from the number of edges
    // since reset release; digit d occupies [d*P, d*P+DIV) of a 4*P frame.
    task automatic model_update(input logic r, input logic ld,
                                input logic [15:0] v, input logic [3:0] d);
        int p, f, dg, wi;
        logic bl;
        if (r) ncyc = 0; else ncyc++;
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                m_disp[m] = 16'h0; m_ddp[m] = 4'h0; m_pv[m] = 1'b0;
                m_nib[m] = 4'h0;   m_dp[m] = 1'b1;
                e_an[m] = 4'b1111; e_fs[m] = 1'b0; e_idx[m] = 2'd3;
                ph[m] = -1;
            end else begin
                p  = DIV + gapv[m];
                f  = 4 * p;
                ph[m] = (ncyc - 1) % f;
                dg = ph[m] / p;
                wi = ph[m] % p;
                if (ph[m] == 0) begin
                    if (ld) begin
                        m_disp[m] = v; m_ddp[m] = d;
                    end else if (m_pv[m]) begin
                        m_disp[m] = m_pend[m]; m_ddp[m] = m_pdp[m];
                    end
                    m_pv[m] = 1'b0;
                end else if (ld) begin
                    m_pend[m] = v; m_pdp[m] = d; m_pv[m] = 1'b1;
                end
                e_idx[m] = 2'(dg);
                e_fs[m]  = (ph[m] == 0);
                e_an[m]  = 4'b1111;
                if (wi < DIV) begin
                    m_nib[m] = m_disp[m][4*dg +: 4];
                    m_dp[m]  = ~m_ddp[m][dg];
                    bl = 1'b0;
`ifdef SSD_SCAN_LZ_BLANK_EN
                    bl = (dg != 0) && ((m_disp[m] >> (4*dg)) == 16'h0) && !m_ddp[m][dg];
`endif
                    if (!bl) e_an[m] = ~(4'b0001 << dg);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("anode0",  {12'h0, an0},  {12'h0, e_an[0]});
        chk("nibble0", {12'h0, nib0}, {12'h0, m_nib[0]});
        chk("dp0",     {15'h0, dp0},  {15'h0, m_dp[0]});
        chk("fs0",     {15'h0, fs0},  {15'h0, e_fs[0]});
        chk("idx0",    {14'h0, idx0}, {14'h0, e_idx[0]});
        chk("anode1",  {12'h0, an1},  {12'h0, e_an[1]});
        chk("nibble1", {12'h0, nib1}, {12'h0, m_nib[1]});
        chk("dp1",     {15'h0, dp1},  {15'h0, m_dp[1]});
        chk("fs1",     {15'h0, fs1},  {15'h0, e_fs[1]});
        chk("idx1",    {14'h0, idx1}, {14'h0, e_idx[1]});
        chk("onehot0", 16'($countones(~an0) <= 1), 16'h1);
        chk("onehot1", 16'($countones(~an1) <= 1), 16'h1);
    endtask

    task automatic step(input logic r, input logic ld,
                        input logic [15:0] v, input logic [3:0] d);
        reset = r; load = ld; value = v; dp_in = d;
        @(posedge clk);
        model_update(r, ld, v, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    // Idle until instance 0 reaches frame position target (bounded by one frame).
    task automatic wait_ph(input int target);
        bit hit = 1'b0;
        for (int i = 0; i < 4 * (DIV + 1) + 1; i++) begin
            if (ph[0] == target) begin
                hit = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 16'h0, 4'h0);
        end
        chk("wait_phase", 16'(hit), 16'h1);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0;
        ph[0] = -1; ph[1] = -1; ncyc = 0;

        // Reset held three cycles, then first DRIVE is digit 0 after one gap
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
        chk("rst_anode", {12'h0, an0}, 16'h000f);
        step(1'b0, 1'b1, 16'h1234, 4'h0);
        chk("first_drive", {12'h0, an0}, 16'h000e);
        chk("first_fs", {15'h0, fs0}, 16'h1);

        // Scan order over two frames
        idle(40);

        // Tear-free: load during digit 2 drive
        wait_ph(11);
        step(1'b0, 1'b1, 16'hABCD, 4'h0);
        idle(30);

        // Load in the frame_start cycle goes to pending
        wait_ph(0);
        step(1'b0, 1'b1, 16'h0F00, 4'h0);
        idle(25);

        // Double load within a frame: last wins
        wait_ph(3);
        step(1'b0, 1'b1, 16'h1111, 4'h0);
        idle(4);
        step(1'b0, 1'b1, 16'h2222, 4'h0);
        idle(40);

        // Decimal point on digit 2; GAP=0 instance never blanks, dp aligned
        step(1'b0, 1'b1, 16'h5678, 4'b0100);
        idle(20);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            chk("gap0_no_off", 16'(an1 == 4'b1111), 16'h0);
            chk("gap0_dp_align", 16'((dp1 == 1'b0) != (an1 == 4'b1011)), 16'h0);
        end

        // Randomized loads
        for (int i = 0; i < 300; i++)
            step(1'b0, ($urandom % 6) == 0, 16'($urandom), 4'($urandom));

        // Reset mid-operation discards pending and blanks at once
        step(1'b0, 1'b1, 16'h9999, 4'h0);
        step(1'b1, 1'b1, 16'hBEEF, 4'hf);
        chk("midrst_anode", {12'h0, an0}, 16'h000f);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(45);

`ifdef SSD_SCAN_LZ_BLANK_EN
        step(1'b0, 1'b1, 16'h0005, 4'h0);
        idle(45);
        step(1'b0, 1'b1, 16'h0005, 4'b0100);
        idle(45);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
